// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if -- request/response bundle between the two requesters, the
// dm_arbiter and the single-port data memory.
//
// Signals:
//   Req0/1, We0/1, Adr0/1, Din0/1, Bop0/1 : requester commands into the arbiter
//   Gnt0/1                                : same-cycle grant back to the requester
//   Ack0/1, Dout0/1, Err0/1               : registered completion back to the requester
//   DmWrEn, DmAdr, DmDataIn, DmBop        : arbiter -> data memory
//   DmDataOut                             : data memory -> arbiter (combinational read)
//
// Modports:
//   slave  : the arbiter's view
//   master : the environment's view (requesters plus memory)
interface dm_arbiter_if;
    logic        Req0;
    logic        Req1;
    logic        We0;
    logic        We1;
    logic [31:0] Adr0;
    logic [31:0] Adr1;
    logic [31:0] Din0;
    logic [31:0] Din1;
    logic [1:0]  Bop0;
    logic [1:0]  Bop1;
    logic        Gnt0;
    logic        Gnt1;
    logic        Ack0;
    logic        Ack1;
    logic [31:0] Dout0;
    logic [31:0] Dout1;
    logic        Err0;
    logic        Err1;
    logic        DmWrEn;
    logic [31:0] DmAdr;
    logic [31:0] DmDataIn;
    logic [1:0]  DmBop;
    logic [31:0] DmDataOut;

    modport slave (
        input  Req0, Req1, We0, We1, Adr0, Adr1, Din0, Din1, Bop0, Bop1, DmDataOut,
        output Gnt0, Gnt1, Ack0, Ack1, Dout0, Dout1, Err0, Err1,
               DmWrEn, DmAdr, DmDataIn, DmBop
    );

    modport master (
        output Req0, Req1, We0, We1, Adr0, Adr1, Din0, Din1, Bop0, Bop1, DmDataOut,
        input  Gnt0, Gnt1, Ack0, Ack1, Dout0, Dout1, Err0, Err1,
               DmWrEn, DmAdr, DmDataIn, DmBop
    );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter -- two-requester arbiter and sequencer in front of the single-port
// data memory. Requester 0 is the CPU load/store path, requester 1 the
// loader/debug port. One request is granted at a time (IDLE), its command is
// registered and driven to the memory for exactly one cycle (ACCESS), and the
// owner receives Ack (plus Dout for loads and Err) on the following cycle.
//
// Ports:
//   Clk : rising-edge clock
//   Rst : asynchronous reset, active-high
//   bus : dm_arbiter_if.slave (requester commands, grants, completions, DM bus)
//
// Parameters:
//   PRIO_FIXED : 0 = round-robin between requesters, 1 = requester 0 always wins
//   DM_WORDS   : number of memory words; byte addresses >= DM_WORDS*4 are rejected
//
// Optional feature macro: DMARB_ALIGN_CHECK_EN
//   When defined, a word access (Bop=00) with Adr[1:0] != 00 is rejected like an
//   out-of-range access (no write, Dout=0, Err=1). When undefined it passes through.
module dm_arbiter #(
    parameter int unsigned PRIO_FIXED = 0,
    parameter int unsigned DM_WORDS   = 1024
) (
    input logic         Clk,
    input logic         Rst,
    dm_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_e;

    localparam logic [32:0] ADR_LIMIT = 33'(DM_WORDS) * 33'd4;

    state_e      state_q, state_d;
    logic        last_q, last_d;      // index of the last granted requester
    logic        any_req;
    logic        win;                 // index of the requester that wins this cycle

    logic        sel_we;
    logic [31:0] sel_adr;
    logic [31:0] sel_din;
    logic [1:0]  sel_bop;
    logic        sel_err;

    logic        cmd_we_q;
    logic [31:0] cmd_adr_q;
    logic [31:0] cmd_din_q;
    logic [1:0]  cmd_bop_q;
    logic        cmd_own_q;
    logic        cmd_err_q;

    logic [1:0]  ack_q;
    logic [1:0]  err_q;
    logic [31:0] dout0_q;
    logic [31:0] dout1_q;
    logic [31:0] rdata;

    logic        gnt0;
    logic        gnt1;
    logic        dm_wren;

    // State register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Next-state logic, including the arbitration decision
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        any_req = bus.Req0 | bus.Req1;
        if (bus.Req0 && bus.Req1) begin
            win = (PRIO_FIXED != 0) ? 1'b0 : ~last_q;
        end else begin
            win = bus.Req1;
        end
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ACCESS;
                    last_d  = win;
                end
            end
            ACCESS:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: grants in IDLE, memory write strobe in ACCESS
    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        dm_wren = 1'b0;
        if (state_q == IDLE) begin
            gnt0 = any_req & ~win;
            gnt1 = any_req & win;
        end else begin
            dm_wren = cmd_we_q & ~cmd_err_q;
        end
    end

    // Winner's command fields and the address check on them
    always_comb begin
        sel_we  = win ? bus.We1  : bus.We0;
        sel_adr = win ? bus.Adr1 : bus.Adr0;
        sel_din = win ? bus.Din1 : bus.Din0;
        sel_bop = win ? bus.Bop1 : bus.Bop0;
        sel_err = ({1'b0, sel_adr} >= ADR_LIMIT);
`ifdef DMARB_ALIGN_CHECK_EN
        if ((sel_bop == 2'b00) && (sel_adr[1:0] != 2'b00)) begin
            sel_err = 1'b1;
        end
`endif
    end

    // Rejected loads return zero instead of whatever the memory presents
    assign rdata = cmd_err_q ? '0 : bus.DmDataOut;

    // Command register and completion registers
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cmd_we_q  <= 1'b0;
            cmd_adr_q <= '0;
            cmd_din_q <= '0;
            cmd_bop_q <= '0;
            cmd_own_q <= 1'b0;
            cmd_err_q <= 1'b0;
            ack_q     <= '0;
            err_q     <= '0;
            dout0_q   <= '0;
            dout1_q   <= '0;
        end else begin
            ack_q <= '0;
            err_q <= '0;
            if ((state_q == IDLE) && any_req) begin
                cmd_we_q  <= sel_we;
                cmd_adr_q <= sel_adr;
                cmd_din_q <= sel_din;
                cmd_bop_q <= sel_bop;
                cmd_own_q <= win;
                cmd_err_q <= sel_err;
            end
            if (state_q == ACCESS) begin
                ack_q[cmd_own_q] <= 1'b1;
                err_q[cmd_own_q] <= cmd_err_q;
                // Stores leave the owner's Dout untouched
                if (!cmd_we_q) begin
                    if (cmd_own_q) begin
                        dout1_q <= rdata;
                    end else begin
                        dout0_q <= rdata;
                    end
                end
            end
        end
    end

    assign bus.Gnt0     = gnt0;
    assign bus.Gnt1     = gnt1;
    assign bus.Ack0     = ack_q[0];
    assign bus.Ack1     = ack_q[1];
    assign bus.Err0     = err_q[0];
    assign bus.Err1     = err_q[1];
    assign bus.Dout0    = dout0_q;
    assign bus.Dout1    = dout1_q;
    assign bus.DmWrEn   = dm_wren;
    assign bus.DmAdr    = cmd_adr_q;
    assign bus.DmDataIn = cmd_din_q;
    assign bus.DmBop    = cmd_bop_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter -- directed bench for dm_arbiter with a byte-addressed,
// little-endian data memory model. A second instance with PRIO_FIXED=1 is
// driven in parallel for the fixed-priority grant pattern.
module tb_dm_arbiter;

    logic Clk;
    logic Rst;

    int errors;
    int checks;

    dm_arbiter_if bus ();
    dm_arbiter_if busf ();

    dm_arbiter #(
        .PRIO_FIXED (0),
        .DM_WORDS   (1024)
    ) u_dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    dm_arbiter #(
        .PRIO_FIXED (1),
        .DM_WORDS   (1024)
    ) u_dut_fixed (
        .Clk (Clk),
        .Rst (Rst),
        .bus (busf)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Data memory model: 4096 bytes, little-endian words, byte ops on Bop[1]
    logic [7:0]  mem [0:4095];
    logic [11:0] ba;
    logic [11:0] wa;

    always_comb begin
        ba = bus.DmAdr[11:0];
        wa = {bus.DmAdr[11:2], 2'b00};
        case (bus.DmBop)
            2'b11:   bus.DmDataOut = {{24{mem[ba][7]}}, mem[ba]};
            2'b10:   bus.DmDataOut = {24'h0, mem[ba]};
            default: bus.DmDataOut = {mem[wa + 12'd3], mem[wa + 12'd2], mem[wa + 12'd1], mem[wa]};
        endcase
    end

    always @(posedge Clk) begin
        if (bus.DmWrEn) begin
            if (bus.DmBop == 2'b00) begin
                mem[wa]          <= bus.DmDataIn[7:0];
                mem[wa + 12'd1]  <= bus.DmDataIn[15:8];
                mem[wa + 12'd2]  <= bus.DmDataIn[23:16];
                mem[wa + 12'd3]  <= bus.DmDataIn[31:24];
            end else begin
                mem[ba] <= bus.DmDataIn[7:0];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete transaction: request at the current cycle (N), checked for
    // grant in N, memory strobe in N+1 and completion in N+2. Returns just after
    // the N+2 edge so the next call requests in N+2.
    task automatic xact(input string tag, input bit who, input bit we,
                        input logic [31:0] adr, input logic [31:0] din,
                        input logic [1:0] bop, input bit exp_wr, input bit exp_err,
                        input logic [31:0] exp_dout);
        if (!who) begin
            bus.Req0 = 1'b1; bus.We0 = we; bus.Adr0 = adr; bus.Din0 = din; bus.Bop0 = bop;
        end else begin
            bus.Req1 = 1'b1; bus.We1 = we; bus.Adr1 = adr; bus.Din1 = din; bus.Bop1 = bop;
        end
        @(negedge Clk);
        chk({tag, ".gnt"}, {30'h0, bus.Gnt0, bus.Gnt1}, who ? 32'd1 : 32'd2);
        @(posedge Clk); #1;
        bus.Req0 = 1'b0;
        bus.Req1 = 1'b0;
        chk({tag, ".wren"}, {31'h0, bus.DmWrEn}, {31'h0, exp_wr});
        chk({tag, ".dmadr"}, bus.DmAdr, adr);
        chk({tag, ".gnt_access"}, {30'h0, bus.Gnt0, bus.Gnt1}, 32'd0);
        @(posedge Clk); #1;
        chk({tag, ".ack"}, {30'h0, bus.Ack0, bus.Ack1}, who ? 32'd1 : 32'd2);
        chk({tag, ".err"}, {31'h0, who ? bus.Err1 : bus.Err0}, {31'h0, exp_err});
        chk({tag, ".dout"}, who ? bus.Dout1 : bus.Dout0, exp_dout);
    endtask

    bit exp_al_err;
    bit exp_al_wr;
    logic [31:0] exp_al_rd;
    int acks_seen;

    initial begin
        errors = 0;
        checks = 0;
        foreach (mem[i]) mem[i] = 8'h00;
        bus.Req0 = 1'b0; bus.We0 = 1'b0; bus.Adr0 = '0; bus.Din0 = '0; bus.Bop0 = 2'b00;
        bus.Req1 = 1'b0; bus.We1 = 1'b0; bus.Adr1 = '0; bus.Din1 = '0; bus.Bop1 = 2'b00;
        busf.Req0 = 1'b0; busf.We0 = 1'b0; busf.Adr0 = '0; busf.Din0 = '0; busf.Bop0 = 2'b00;
        busf.Req1 = 1'b0; busf.We1 = 1'b0; busf.Adr1 = '0; busf.Din1 = '0; busf.Bop1 = 2'b00;
        busf.DmDataOut = '0;
        Rst = 1'b1;

        // Reset values
        #3;
        chk("rst.gnt", {30'h0, bus.Gnt0, bus.Gnt1}, 32'd0);
        chk("rst.ack", {30'h0, bus.Ack0, bus.Ack1}, 32'd0);
        chk("rst.err", {30'h0, bus.Err0, bus.Err1}, 32'd0);
        chk("rst.wren", {31'h0, bus.DmWrEn}, 32'd0);
        chk("rst.dmadr", bus.DmAdr, 32'd0);
        chk("rst.dmdin", bus.DmDataIn, 32'd0);
        chk("rst.dmbop", {30'h0, bus.DmBop}, 32'd0);
        chk("rst.dout0", bus.Dout0, 32'd0);
        chk("rst.dout1", bus.Dout1, 32'd0);
        @(posedge Clk); #1;
        Rst = 1'b0;

        // Word store/load round trip on requester 0
        xact("st0_word",  1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b00, 1'b1, 1'b0, 32'h0);
        xact("ld0_word",  1'b0, 1'b0, 32'h10, 32'h0,        2'b00, 1'b0, 1'b0, 32'hDEADBEEF);
        // Byte store then signed/unsigned byte loads on requester 1
        xact("st1_byte",  1'b1, 1'b1, 32'h13, 32'h80,       2'b10, 1'b1, 1'b0, 32'h0);
        xact("ld1_sbyte", 1'b1, 1'b0, 32'h13, 32'h0,        2'b11, 1'b0, 1'b0, 32'hFFFFFF80);
        xact("ld1_ubyte", 1'b1, 1'b0, 32'h13, 32'h0,        2'b10, 1'b0, 1'b0, 32'h00000080);
        // Range boundary: last valid byte, then first invalid address
        xact("ld0_last",  1'b0, 1'b0, 32'hFFF,  32'h0,      2'b10, 1'b0, 1'b0, 32'h0);
        xact("ld0_oor",   1'b0, 1'b0, 32'h1000, 32'h0,      2'b00, 1'b0, 1'b1, 32'h0);
        xact("st0_oor",   1'b0, 1'b1, 32'h1000, 32'h1234,   2'b00, 1'b0, 1'b1, 32'h0);
        // The byte store above replaced only the top byte of word 0x10
        xact("ld0_merge", 1'b0, 1'b0, 32'h10, 32'h0,        2'b00, 1'b0, 1'b0, 32'h80ADBEEF);

        // Misaligned word store
`ifdef DMARB_ALIGN_CHECK_EN
        exp_al_err = 1'b1; exp_al_wr = 1'b0; exp_al_rd = 32'h0;
`else
        exp_al_err = 1'b0; exp_al_wr = 1'b1; exp_al_rd = 32'hCAFEF00D;
`endif
        xact("st0_misal", 1'b0, 1'b1, 32'h22, 32'hCAFEF00D, 2'b00, exp_al_wr, exp_al_err, 32'h80ADBEEF);
        xact("ld0_misal", 1'b0, 1'b0, 32'h20, 32'h0,        2'b00, 1'b0, 1'b0, exp_al_rd);

        // Reset during ACCESS of a store
        bus.Req0 = 1'b1; bus.We0 = 1'b1; bus.Adr0 = 32'h40; bus.Din0 = 32'h55AA55AA; bus.Bop0 = 2'b00;
        @(negedge Clk);
        chk("rstacc.gnt", {31'h0, bus.Gnt0}, 32'd1);
        @(posedge Clk); #1;
        bus.Req0 = 1'b0;
        chk("rstacc.wren_before", {31'h0, bus.DmWrEn}, 32'd1);
        #2;
        Rst = 1'b1;
        #1;
        chk("rstacc.wren_async", {31'h0, bus.DmWrEn}, 32'd0);
        chk("rstacc.dmadr", bus.DmAdr, 32'd0);
        chk("rstacc.dmdin", bus.DmDataIn, 32'd0);
        chk("rstacc.dout0", bus.Dout0, 32'd0);
        @(negedge Clk);
        Rst = 1'b0;
        acks_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            if (bus.Ack0 || bus.Ack1) acks_seen++;
        end
        chk("rstacc.no_ack", acks_seen, 32'd0);

        // Both requesters held high: round-robin alternates starting with 0,
        // fixed priority grants only requester 0; one grant every 2 cycles
        @(posedge Clk); #1;
        bus.Req0 = 1'b1; bus.We0 = 1'b0; bus.Adr0 = 32'h10; bus.Bop0 = 2'b00;
        bus.Req1 = 1'b1; bus.We1 = 1'b0; bus.Adr1 = 32'h10; bus.Bop1 = 2'b00;
        busf.Req0 = 1'b1; busf.Adr0 = 32'h10;
        busf.Req1 = 1'b1; busf.Adr1 = 32'h14;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            chk($sformatf("rr.gnt%0d", i), {30'h0, bus.Gnt0, bus.Gnt1},
                (i % 2 == 1) ? 32'd0 : (((i / 2) % 2 == 0) ? 32'd2 : 32'd1));
            chk($sformatf("fixed.gnt%0d", i), {30'h0, busf.Gnt0, busf.Gnt1},
                (i % 2 == 1) ? 32'd0 : 32'd2);
            @(posedge Clk); #1;
        end
        bus.Req0 = 1'b0;
        bus.Req1 = 1'b0;
        busf.Req0 = 1'b0;
        busf.Req1 = 1'b0;
        repeat (3) @(posedge Clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port data memory.
- Requester 0 is the CPU load/store path. Requester 1 is the program/data loader or debug port.
- Grants one request at a time, registers the granted command, and drives the DM write-enable, address, data and byte-operation inputs for exactly one cycle.
- Returns the DM read data and an Ack pulse to the owning requester.

Parameters:
- PRIO_FIXED, 0, 0 = round-robin between requesters; 1 = requester 0 always wins.
- DM_WORDS, 1024, number of DM words; addresses at or above DM_WORDS*4 are out of range.

Ports:
- Clk  input  1  rising-edge clock
- Rst  input  1  asynchronous reset, active-high
- Req0 / Req1  input  1  request valid
- We0 / We1  input  1  1 = store, 0 = load
- Adr0 / Adr1  input  32  byte address
- Din0 / Din1  input  32  store data (byte stores use bits [7:0])
- Bop0 / Bop1  input  2  00 = word, 11 = signed byte load, 10 = unsigned byte load / byte store
- Gnt0 / Gnt1  output  1  request accepted this cycle (combinational from state and Req)
- Ack0 / Ack1  output  1  registered one-cycle pulse: access completed
- Dout0 / Dout1  output  32  registered load data, valid while Ack is high
- Err0 / Err1  output  1  registered, valid with Ack (see Optional Feature)
- DmWrEn  output  1  to DM WrEn
- DmAdr  output  32  to DM Adr
- DmDataIn  output  32  to DM DataIn
- DmBop  output  2  to DM Boperation
- DmDataOut  input  32  from DM DataOut (combinational read)

Behaviour:
- Reset (asynchronous, Rst=1):
  - State = IDLE.
  - Last-winner pointer = 1, so requester 0 wins the first tie.
  - All Gnt, Ack, Err, DmWrEn = 0; Dout0, Dout1, DmAdr, DmDataIn = 0; DmBop = 00.
- FSM states: IDLE and ACCESS.
- IDLE:
  - If any Req is high, exactly one Gnt is asserted in the same cycle.
  - Winner when only one requester asks: that requester.
  - Winner when both ask, PRIO_FIXED=0: the requester that was not the last winner.
  - Winner when both ask, PRIO_FIXED=1: requester 0.
  - At the clock edge: the winner's We, Adr, Din, Bop are latched into the command register, the last-winner pointer is updated, and the state moves to ACCESS.
  - If no Req is high: stay in IDLE, DmWrEn = 0.
- ACCESS (exactly one cycle):
  - DmAdr, DmDataIn and DmBop come from the command register.
  - DmWrEn = latched We, gated by the error check.
  - Both Gnt outputs are 0.
  - At the clock edge: the owner's Dout captures DmDataOut (loads only; Dout holds its previous value on stores), the owner's Ack is set for one cycle, and the state returns to IDLE.
- Timing:
  - Grant in cycle N, DM access in cycle N+1, Ack/Dout visible in cycle N+2.
  - Peak throughput is one access per 2 cycles.
  - A store is committed to DM at the end of cycle N+1, so a load granted in cycle N+2 reads the new value.
- Handshake rules:
  - A requester holds Req and its fields stable until it sees Gnt.
  - The cycle after Gnt, the requester may drop Req or present a new command.
  - Req may be held high across Ack to issue back-to-back requests.
  - The arbiter never starves a requester: with PRIO_FIXED=0 and both requesters always asking, grants alternate 0,1,0,1.
- Out-of-range address (Adr >= DM_WORDS*4):
  - Store: DmWrEn is forced to 0.
  - Load: Dout returns 0.
  - Ack still pulses and Err is set.
- Dropping Req in IDLE without a Gnt is legal; nothing is latched.
- Rst asserted while in ACCESS:
  - Immediate return to IDLE; DmWrEn drops asynchronously.
  - The store may be lost.
  - No Ack is issued after reset is released.

Optional Feature:
- Macro: DMARB_ALIGN_CHECK_EN.
- Defined: a word access (Bop=00) with Adr[1:0] != 00 is treated like an out-of-range access: no DM write, Dout=0, Ack with Err=1.
- Not defined: misaligned word accesses pass through unchanged; Err is raised only for out-of-range addresses.

Test Plan:
- Reset, then Req0 store word Adr=0x10, Din=0xDEADBEEF, then Req0 load word at 0x10 -> Gnt0 in cycle N, DmWrEn=1 in N+1, Ack0 in N+2; the load then returns Dout0=0xDEADBEEF with Err0=0.
- Req1 byte store (Bop=10) Adr=0x13, Din=0x80, then Req1 signed byte load (Bop=11) at 0x13 -> Dout1=0xFFFFFF80; an unsigned load (Bop=10) returns 0x00000080.
- Req0 and Req1 held high for 8 cycles, PRIO_FIXED=0 -> grants 0,1,0,1 with one access every 2 cycles; with PRIO_FIXED=1, only Gnt0 asserts.
- Req0 load Adr=0x1000 (DM_WORDS=1024) -> Ack0=1, Err0=1, Dout0=0, DmWrEn never asserted.
- Req0 store granted, Rst pulsed during ACCESS -> state IDLE, all outputs at reset values, no Ack0 after reset is released.
- With DMARB_ALIGN_CHECK_EN defined: word store at Adr=0x22 -> no DM write, Ack0 with Err0=1. Without the macro: the write reaches DM and Err0=0.
